// File: rtl/pss_generator.sv
// NR PSS generator: m-sequence BPSK symbols on an AXI-stream master, one-shot or periodic trigger.
// Optional PSS_GEN_SUBCARRIER_MAP_EN frames the sequence inside a 240-symbol SSB with zero guards.
module pss_generator #(
    parameter int unsigned OUT_DW       = 32,
    parameter int          AMPLITUDE    = 8192,
    parameter int unsigned SSB_INTERVAL = 38400
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [1:0]        N_id_2_i,
    input  logic              start_i,
    input  logic              auto_i,
    output logic [OUT_DW-1:0] m_axis_out_tdata,
    output logic              m_axis_out_tvalid,
    input  logic              m_axis_out_tready,
    output logic              m_axis_out_tlast,
    output logic              busy_o,
    output logic              overrun_o
);

    localparam int unsigned HalfDw = OUT_DW / 2;
    localparam int unsigned CntW   = (SSB_INTERVAL > 1) ? $clog2(SSB_INTERVAL) : 1;
    localparam logic [6:0]  Seed   = 7'b1110110;
    localparam logic [HalfDw-1:0] AmpPos = HalfDw'(AMPLITUDE);
    localparam logic [HalfDw-1:0] AmpNeg = HalfDw'(-AMPLITUDE);

`ifdef PSS_GEN_SUBCARRIER_MAP_EN
    localparam logic [7:0] LastSym    = 8'd239;
    localparam logic       FirstIsPss = 1'b0;
`else
    localparam logic [7:0] LastSym    = 8'd126;
    localparam logic       FirstIsPss = 1'b1;
`endif

    typedef enum logic [1:0] {StIdle, StSeed, StLoad, StRun} state_e;

    state_e            state_q;
    logic [6:0]        lfsr_q;
    logic [6:0]        seed_cnt_q;
    logic [1:0]        n_id_q;
    logic [7:0]        sym_idx_q;
    logic [CntW-1:0]   period_cnt_q;
    logic [OUT_DW-1:0] tdata_q;
    logic              tvalid_q;
    logic              tlast_q;
    logic              busy_q;
    logic              overrun_q;

    logic       auto_wrap;
    logic       trig;
    logic [6:0] seed_steps;
    logic [7:0] sym_next;
    logic       next_is_pss;

    function automatic logic [6:0] lfsr_step(input logic [6:0] s);
        return {s[4] ^ s[0], s[6:1]};
    endfunction

    function automatic logic [OUT_DW-1:0] map_bit(input logic b);
        return {{(OUT_DW - HalfDw){1'b0}}, (b ? AmpNeg : AmpPos)};
    endfunction

    assign auto_wrap = auto_i && (period_cnt_q == CntW'(SSB_INTERVAL - 1));
    assign trig      = start_i || auto_wrap;

    always_comb begin
        seed_steps = 7'd0;
        unique case (n_id_q)
            2'd1:    seed_steps = 7'd43;
            2'd2:    seed_steps = 7'd86;
            default: seed_steps = 7'd0;
        endcase
        sym_next = sym_idx_q + 8'd1;
`ifdef PSS_GEN_SUBCARRIER_MAP_EN
        next_is_pss = (sym_next >= 8'd56) && (sym_next <= 8'd182);
`else
        next_is_pss = 1'b1;
`endif
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            period_cnt_q <= '0;
        end else if (!auto_i || auto_wrap) begin
            period_cnt_q <= '0;
        end else begin
            period_cnt_q <= period_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            lfsr_q     <= Seed;
            seed_cnt_q <= '0;
            n_id_q     <= '0;
            sym_idx_q  <= '0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            // Any trigger outside IDLE is dropped; the frame in flight continues untouched.
            overrun_q <= trig && (state_q != StIdle);
            unique case (state_q)
                StIdle: begin
                    if (trig) begin
                        if (N_id_2_i == 2'd3) begin
                            overrun_q <= 1'b1;
                        end else begin
                            n_id_q     <= N_id_2_i;
                            lfsr_q     <= Seed;
                            seed_cnt_q <= '0;
                            busy_q     <= 1'b1;
                            state_q    <= StSeed;
                        end
                    end
                end
                StSeed: begin
                    if (seed_cnt_q == seed_steps) begin
                        state_q <= StLoad;
                    end else begin
                        lfsr_q     <= lfsr_step(lfsr_q);
                        seed_cnt_q <= seed_cnt_q + 7'd1;
                    end
                end
                StLoad: begin
                    sym_idx_q <= '0;
                    tvalid_q  <= 1'b1;
                    tlast_q   <= 1'b0;
                    if (FirstIsPss) begin
                        tdata_q <= map_bit(lfsr_q[0]);
                        lfsr_q  <= lfsr_step(lfsr_q);
                    end else begin
                        tdata_q <= '0;
                    end
                    state_q <= StRun;
                end
                StRun: begin
                    if (tvalid_q && m_axis_out_tready) begin
                        if (sym_idx_q == LastSym) begin
                            tvalid_q <= 1'b0;
                            tlast_q  <= 1'b0;
                            busy_q   <= 1'b0;
                            state_q  <= StIdle;
                        end else begin
                            sym_idx_q <= sym_next;
                            tlast_q   <= (sym_next == LastSym);
                            // lfsr_q[0] already holds the bit for the next PSS symbol.
                            if (next_is_pss) begin
                                tdata_q <= map_bit(lfsr_q[0]);
                                lfsr_q  <= lfsr_step(lfsr_q);
                            end else begin
                                tdata_q <= '0;
                            end
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign m_axis_out_tdata  = tdata_q;
    assign m_axis_out_tvalid = tvalid_q;
    assign m_axis_out_tlast  = tlast_q;
    assign busy_o            = busy_q;
    assign overrun_o         = overrun_q;

endmodule

// File: tb/tb_pss_generator.sv
// Self-checking bench for pss_generator against a sequence-level PSS model.
module tb_pss_generator;

`ifdef PSS_GEN_SUBCARRIER_MAP_EN
    localparam int FrameLen = 240;
    localparam int PssOff   = 56;
`else
    localparam int FrameLen = 127;
    localparam int PssOff   = 0;
`endif
    localparam int Interval = 200;

    logic        clk;
    logic        reset;
    logic [1:0]  n_id;
    logic        start;
    logic        auto_en;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic        busy;
    logic        overrun;

    pss_generator #(
        .OUT_DW      (32),
        .AMPLITUDE   (8192),
        .SSB_INTERVAL(Interval)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .N_id_2_i         (n_id),
        .start_i          (start),
        .auto_i           (auto_en),
        .m_axis_out_tdata (tdata),
        .m_axis_out_tvalid(tvalid),
        .m_axis_out_tready(tready),
        .m_axis_out_tlast (tlast),
        .busy_o           (busy),
        .overrun_o        (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    bit          pss_x[127];
    logic [31:0] got_data[$];
    logic        got_last[$];
    logic [31:0] frame0[$];
    int          lat;
    int          stall_err;
    int          ovr_pulses = 0;
    int          ovr_long = 0;
    logic        ovr_prev = 1'b0;

    always @(negedge clk) begin
        if (overrun === 1'b1) begin
            ovr_pulses++;
            if (ovr_prev === 1'b1) ovr_long++;
        end
        ovr_prev = overrun;
    end

    // Expected {Q,I} word for symbol idx of a frame with cell-ID part N.
    function automatic logic [31:0] exp_word(input int n, input int idx);
        int p = idx - PssOff;
        logic signed [15:0] iv;
        if (p < 0 || p > 126) return 32'h0;
        iv = pss_x[(p + 43 * n) % 127] ? -16'sd8192 : 16'sd8192;
        return {16'h0, iv};
    endfunction

    function automatic int count_mismatch(input int n);
        int mm = 0;
        for (int i = 0; i < got_data.size(); i++)
            if (got_data[i] !== exp_word(n, i) || got_last[i] !== (i == FrameLen - 1)) mm++;
        return mm;
    endfunction

    // Fires one start_i and collects a full frame; stalls are checked for stability.
    task automatic run_frame(input logic [1:0] n, input bit rnd);
        logic [31:0] pd;
        logic        pl;
        bit          stalled;
        int          budget;
        got_data.delete();
        got_last.delete();
        stall_err = 0;
        stalled   = 1'b0;
        pd        = '0;
        pl        = 1'b0;
        @(negedge clk);
        n_id   = n;
        start  = 1'b1;
        tready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        while (tvalid !== 1'b1 && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        if (tvalid !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL frame_start_timeout n=%0d: no tvalid within %0d cycles", n, lat);
            return;
        end
        budget = 0;
        while (got_data.size() < FrameLen && budget < 4000) begin
            if (stalled && (tvalid !== 1'b1 || tdata !== pd || tlast !== pl)) stall_err++;
            tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (tvalid === 1'b1 && tready) begin
                got_data.push_back(tdata);
                got_last.push_back(tlast);
                stalled = 1'b0;
            end else begin
                stalled = (tvalid === 1'b1);
                pd      = tdata;
                pl      = tlast;
            end
            @(negedge clk);
            budget++;
        end
        tready = 1'b0;
        if (got_data.size() < FrameLen) begin
            checks++;
            errors++;
            $display("FAIL frame_collect_timeout: got %0d symbols, want %0d", got_data.size(),
                     FrameLen);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks += 5;
        if (tdata !== 32'h0) begin errors++; $display("FAIL reset_tdata: %h want 0", tdata); end
        if (tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: %b want 0", tvalid); end
        if (tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: %b want 0", tlast); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: %b want 0", busy); end
        if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: %b want 0", overrun); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_nid0();
        int want7[7] = '{8192, -8192, -8192, 8192, -8192, -8192, -8192};
        int s = 0;
        int qbad = 0;
        int mm;
        run_frame(2'd0, 1'b0);
        checks += 6;
        if (lat !== 2) begin errors++; $display("FAIL n0_latency: %0d want 2", lat); end
        if (got_data.size() !== FrameLen) begin
            errors++; $display("FAIL n0_count: %0d want %0d", got_data.size(), FrameLen);
        end
        mm = count_mismatch(0);
        if (mm !== 0) begin errors++; $display("FAIL n0_frame: %0d bad symbols want 0", mm); end
        for (int i = 0; i < got_data.size(); i++) begin
            s += int'($signed(got_data[i][15:0]));
            if (got_data[i][31:16] !== 16'h0) qbad++;
        end
        if (s !== -8192) begin errors++; $display("FAIL n0_sum_i: %0d want -8192", s); end
        if (qbad !== 0) begin errors++; $display("FAIL n0_q_zero: %0d nonzero want 0", qbad); end
        if (busy !== 1'b0 || tvalid !== 1'b0) begin
            errors++; $display("FAIL n0_end_idle: busy=%b tvalid=%b want 0 0", busy, tvalid);
        end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (int'($signed(got_data[PssOff + i][15:0])) !== want7[i]) begin
                errors++;
                $display("FAIL n0_first7[%0d]: %0d want %0d", i,
                         int'($signed(got_data[PssOff + i][15:0])), want7[i]);
            end
        end
        frame0 = got_data;
    endtask

    task automatic test_nid12();
        int mm;
        for (int n = 1; n <= 2; n++) begin
            run_frame(2'(n), 1'b0);
            checks += 2;
            if (lat !== 2 + 43 * n) begin
                errors++; $display("FAIL n%0d_latency: %0d want %0d", n, lat, 2 + 43 * n);
            end
            mm = count_mismatch(n);
            if (mm !== 0 || got_data.size() !== FrameLen) begin
                errors++;
                $display("FAIL n%0d_frame: %0d bad of %0d symbols want 0 of %0d", n, mm,
                         got_data.size(), FrameLen);
            end
        end
`ifndef PSS_GEN_SUBCARRIER_MAP_EN
        mm = 0;
        for (int i = 0; i < 127; i++)
            if (got_data[i] !== frame0[(i + 86) % 127]) mm++;
        checks++;
        if (mm !== 0) begin errors++; $display("FAIL n2_rotation: %0d bad want 0", mm); end
`endif
    endtask

    task automatic test_random_ready();
        int n;
        int mm;
        for (int k = 0; k < 3; k++) begin
            n = $urandom_range(0, 2);
            run_frame(2'(n), 1'b1);
            mm = count_mismatch(n);
            checks += 3;
            if (got_data.size() !== FrameLen) begin
                errors++; $display("FAIL rnd_count: %0d want %0d", got_data.size(), FrameLen);
            end
            if (mm !== 0) begin errors++; $display("FAIL rnd_frame n=%0d: %0d bad want 0", n, mm); end
            if (stall_err !== 0) begin
                errors++; $display("FAIL rnd_stall_stable: %0d violations want 0", stall_err);
            end
        end
    endtask

    task automatic test_auto();
        int   rises[$];
        int   sym = 0;
        int   cyc = 0;
        int   mm = 0;
        int   ovr0 = 0;
        int   ovr_long0;
        logic pv = 1'b0;
        @(negedge clk);
        n_id      = 2'd0;
        tready    = 1'b1;
        auto_en   = 1'b1;
        ovr_long0 = ovr_long;
        while (cyc < 1000 && !(rises.size() == 3 && sym == FrameLen)) begin
            start = 1'b0;
            if (tvalid === 1'b1 && pv !== 1'b1) begin
                rises.push_back(cyc);
                sym = 0;
            end
            if (tvalid === 1'b1) begin
                if (tdata !== exp_word(0, sym) || tlast !== (sym == FrameLen - 1)) mm++;
                sym++;
            end
            pv = tvalid;
            if (rises.size() == 2 && cyc == rises[1] + 30) begin
                start = 1'b1;
                ovr0  = ovr_pulses;
            end
            @(negedge clk);
            cyc++;
        end
        auto_en = 1'b0;
        tready  = 1'b0;
        repeat (2) @(negedge clk);
        checks += 4;
        if (rises.size() !== 3) begin
            errors++; $display("FAIL auto_frames: %0d frames want 3", rises.size());
        end else begin
            checks += 2;
            if (rises[0] !== Interval + 2) begin
                errors++; $display("FAIL auto_first: cycle %0d want %0d", rises[0], Interval + 2);
            end
            if (rises[1] - rises[0] !== Interval || rises[2] - rises[1] !== Interval) begin
                errors++;
                $display("FAIL auto_period: %0d %0d want %0d", rises[1] - rises[0],
                         rises[2] - rises[1], Interval);
            end
        end
        if (mm !== 0) begin errors++; $display("FAIL auto_frame_data: %0d bad want 0", mm); end
        if (ovr_pulses - ovr0 !== 1) begin
            errors++; $display("FAIL auto_overrun_count: %0d want 1", ovr_pulses - ovr0);
        end
        if (ovr_long !== ovr_long0) begin
            errors++; $display("FAIL auto_overrun_width: %0d long pulses want 0", ovr_long - ovr_long0);
        end
    endtask

    task automatic test_reset_mid();
        int hs = 0;
        int budget = 0;
        int mm;
        @(negedge clk);
        n_id   = 2'd0;
        start  = 1'b1;
        tready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!(tvalid === 1'b1 && hs == 60) && budget < 400) begin
            if (tvalid === 1'b1) hs++;
            @(negedge clk);
            budget++;
        end
        reset = 1'b1;
        #1;
        checks += 2;
        if (tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_tvalid: %b want 0", tvalid); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: %b want 0", busy); end
        tready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        run_frame(2'd0, 1'b0);
        mm = count_mismatch(0);
        checks += 2;
        if (lat !== 2) begin errors++; $display("FAIL rstmid_latency: %0d want 2", lat); end
        if (mm !== 0 || got_data.size() !== FrameLen) begin
            errors++;
            $display("FAIL rstmid_frame: %0d bad of %0d want 0 of %0d", mm, got_data.size(),
                     FrameLen);
        end
    endtask

    task automatic test_nid3();
        int ovr0;
        int seen = 0;
        @(negedge clk);
        ovr0  = ovr_pulses;
        n_id  = 2'd3;
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        tready = 1'b1;
        repeat (150) begin
            if (tvalid !== 1'b0 || busy !== 1'b0) seen++;
            @(negedge clk);
        end
        tready = 1'b0;
        checks += 2;
        if (seen !== 0) begin errors++; $display("FAIL nid3_no_frame: %0d active cycles want 0", seen); end
        if (ovr_pulses - ovr0 !== 1) begin
            errors++; $display("FAIL nid3_overrun: %0d pulses want 1", ovr_pulses - ovr0);
        end
    endtask

    initial begin
        reset   = 1'b1;
        n_id    = 2'd0;
        start   = 1'b0;
        auto_en = 1'b0;
        tready  = 1'b0;
        pss_x = '{default: 1'b0};
        pss_x[1] = 1'b1; pss_x[2] = 1'b1; pss_x[4] = 1'b1; pss_x[5] = 1'b1; pss_x[6] = 1'b1;
        for (int i = 0; i < 120; i++) pss_x[i + 7] = pss_x[i + 4] ^ pss_x[i];
        test_reset();
        test_nid0();
        test_nid12();
        test_random_ready();
        test_auto();
        test_reset_mid();
        test_nid3();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
